// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-bus arbiter slice.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  localparam logic       PORT_CPU  = 1'b0;
  localparam logic       PORT_DBG  = 1'b1;
  localparam logic [1:0] WORD_MASK = 2'b11;

  // One-hot acknowledge vector for a port id.
  function automatic logic [1:0] port_bit(input logic id);
    return (id == PORT_DBG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational two-way round-robin selector: on a tie the port that was not
// granted last wins.
module rr_pick
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = PORT_CPU;
    if (req[PORT_CPU] && req[PORT_DBG])
      grant_id = ~last_grant;
    else if (req[PORT_DBG])
      grant_id = PORT_DBG;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared memory bus: grants one requester,
// strobes memory until ready or timeout, and returns ack/err/rdata.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_error
);

  arb_state_t  state, state_nxt;
  logic        grant_valid, grant_id;
  logic        last_grant, cur_id, cur_we;
  logic [15:0] cnt;
  logic [31:0] cur_addr, cur_wdata;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_we, misaligned, timed_out;

  rr_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign sel_addr   = (grant_id == PORT_DBG) ? addr1  : addr0;
  assign sel_wdata  = (grant_id == PORT_DBG) ? wdata1 : wdata0;
  assign sel_we     = we[grant_id];
  assign misaligned = |(sel_addr[1:0] & WORD_MASK);
  assign timed_out  = (cnt == 16'(TIMEOUT - 1));

  // cur_addr/cur_wdata load only on aligned grants, so they double as the
  // registered mem_addr/mem_wdata that must hold their value outside BUSY.
  assign mem_addr  = cur_addr;
  assign mem_wdata = cur_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant_valid) state_nxt = misaligned ? RESP : BUSY;
      BUSY: if (mem_ready || timed_out) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= PORT_DBG;
      cur_id     <= PORT_CPU;
      cur_we     <= 1'b0;
      cur_addr   <= '0;
      cur_wdata  <= '0;
      cnt        <= '0;
      ack        <= '0;
      err        <= 1'b0;
      rdata      <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cur_id     <= grant_id;
            last_grant <= grant_id;
            cur_we     <= sel_we;
            cnt        <= '0;
            if (misaligned) begin
              ack   <= port_bit(grant_id);
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              cur_addr  <= sel_addr;
              cur_wdata <= sel_wdata;
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
            end
          end
        end
        BUSY: begin
          // Ready has priority over a timeout expiring on the same edge.
          if (mem_ready) begin
            ack    <= port_bit(cur_id);
            err    <= 1'b0;
            rdata  <= cur_we ? '0 : mem_rdata;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else if (timed_out) begin
            ack    <= port_bit(cur_id);
            err    <= 1'b1;
            rdata  <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          ack   <= '0;
          err   <= 1'b0;
          rdata <= '0;
          if (err) bus_error <= 1'b1;
        end
        default: begin
          ack    <= '0;
          err    <= 1'b0;
          rdata  <= '0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with TIMEOUT=4.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  ack;
  logic        err;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ack      (ack),
    .err      (err),
    .rdata    (rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step();
    step();
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack got %b exp 00", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_en_we got %b exp 00", {mem_en, mem_we}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_mem_addr_wdata got %h exp 0", {mem_addr, mem_wdata}); end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error got %b exp 0", bus_error); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_cpu_read;
    req = 2'b01; we = 2'b00; addr0 = 32'h100;
    mem_rdata = 32'hDEADBEEF; mem_ready = 1'b1;
    step();
    req = 2'b00;
    checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL read_mem_en_we got %b exp 10", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL read_mem_addr got %h exp 100", mem_addr); end
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL read_early_ack got %b exp 00", ack); end
    step();
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL read_ack got %b exp 01", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err got %b exp 0", err); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got %h exp deadbeef", rdata); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL read_mem_en_resp got %b exp 0", mem_en); end
    step();
    checks++; if ({ack, err, rdata} !== 35'h0) begin errors++; $display("FAIL read_after_ack got %h exp 0", {ack, err, rdata}); end
    mem_ready = 1'b0;
  endtask

  task automatic test_simultaneous;
    logic [31:0] exp_addr;
    logic [1:0]  exp_ack;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    req = 2'b11; we = 2'b00; addr0 = 32'h300; addr1 = 32'h400;
    mem_rdata = 32'hA5A5A5A5; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h300 : 32'h400;
      exp_ack  = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
      if (i == 3) req = 2'b00;
      checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL tie_mem_en_%0d got %b exp 1", i, mem_en); end
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL tie_mem_addr_%0d got %h exp %h", i, mem_addr, exp_addr); end
      step();
      checks++; if (ack !== exp_ack) begin errors++; $display("FAIL tie_ack_%0d got %b exp %b", i, ack, exp_ack); end
      checks++; if (rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL tie_rdata_%0d got %h exp a5a5a5a5", i, rdata); end
      step();
      checks++; if ({ack, mem_en} !== 3'b000) begin errors++; $display("FAIL tie_idle_%0d got %b exp 000", i, {ack, mem_en}); end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_debug_write;
    req = 2'b10; we = 2'b10; addr1 = 32'h200; wdata1 = 32'h12345678;
    mem_rdata = 32'hCAFEF00D; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      req = 2'b00;
      checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL wr_mem_en_we_%0d got %b exp 11", i, {mem_en, mem_we}); end
      checks++; if ({mem_addr, mem_wdata} !== {32'h200, 32'h12345678}) begin errors++; $display("FAIL wr_addr_data_%0d got %h exp 0000020012345678", i, {mem_addr, mem_wdata}); end
      checks++; if (ack !== 2'b00) begin errors++; $display("FAIL wr_early_ack_%0d got %b exp 00", i, ack); end
      if (i == 3) mem_ready = 1'b1;
    end
    step();
    mem_ready = 1'b0;
    checks++; if (ack !== 2'b10) begin errors++; $display("FAIL wr_ack got %b exp 10", ack); end
    checks++; if ({err, rdata} !== 33'h0) begin errors++; $display("FAIL wr_err_rdata got %h exp 0", {err, rdata}); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL wr_mem_off got %b exp 00", {mem_en, mem_we}); end
    step();
  endtask

  task automatic test_misaligned;
    int en_seen = 0;
    req = 2'b01; we = 2'b00; addr0 = 32'h102;
    step();
    req = 2'b00;
    if (mem_en) en_seen++;
    checks++; if ({ack, err} !== 3'b011) begin errors++; $display("FAIL mis_ack_err got %b exp 011", {ack, err}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata got %h exp 0", rdata); end
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL mis_mem_addr_hold got %h exp 200", mem_addr); end
    step();
    if (mem_en) en_seen++;
    checks++; if (bus_error !== 1'b1) begin errors++; $display("FAIL mis_bus_error got %b exp 1", bus_error); end
    checks++; if (ack !== 2'b00) begin errors++; $display("FAIL mis_ack_clear got %b exp 00", ack); end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL mis_mem_en got %0d cycles exp 0", en_seen); end
  endtask

  task automatic test_timeout;
    int en_cycles = 0;
    bit done = 0;
    req = 2'b01; we = 2'b00; addr0 = 32'h500;
    mem_rdata = 32'h11111111; mem_ready = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      req = 2'b00;
      if (ack !== 2'b00) done = 1;
      else if (mem_en) en_cycles++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL to_ack_seen got %b exp 1", done); end
    checks++; if (en_cycles !== 4) begin errors++; $display("FAIL to_mem_en_cycles got %0d exp 4", en_cycles); end
    checks++; if ({ack, err} !== 3'b011) begin errors++; $display("FAIL to_ack_err got %b exp 011", {ack, err}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", rdata); end
    step();
  endtask

  task automatic test_ready_at_timeout;
    req = 2'b01; we = 2'b00; addr0 = 32'h504;
    mem_rdata = 32'h11111111; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      req = 2'b00;
      checks++; if ({mem_en, ack} !== 3'b100) begin errors++; $display("FAIL rt_busy_%0d got %b exp 100", i, {mem_en, ack}); end
      if (i == 3) mem_ready = 1'b1;
    end
    step();
    mem_ready = 1'b0;
    checks++; if ({ack, err} !== 3'b010) begin errors++; $display("FAIL rt_ack_err got %b exp 010", {ack, err}); end
    checks++; if (rdata !== 32'h11111111) begin errors++; $display("FAIL rt_rdata got %h exp 11111111", rdata); end
    step();
  endtask

  task automatic test_reset_mid;
    int acks = 0;
    req = 2'b01; we = 2'b00; addr0 = 32'h600; mem_ready = 1'b0;
    step();
    req = 2'b00;
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rm_busy_en got %b exp 1", mem_en); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rm_async_en got %b exp 0", mem_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (ack !== 2'b00) acks++;
    end
    checks++; if (bus_error !== 1'b0) begin errors++; $display("FAIL rm_bus_error got %b exp 0", bus_error); end
    rst = 1'b1;
    step();
    if (ack !== 2'b00) acks++;
    checks++; if (acks !== 0) begin errors++; $display("FAIL rm_no_ack got %0d exp 0", acks); end
    req = 2'b11; addr0 = 32'h700; addr1 = 32'h800; mem_ready = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    req = 2'b00;
    checks++; if ({mem_en, mem_addr} !== {1'b1, 32'h700}) begin errors++; $display("FAIL rm_tie_cpu got %h exp 100000700", {mem_en, mem_addr}); end
    step();
    checks++; if (ack !== 2'b01) begin errors++; $display("FAIL rm_tie_ack got %b exp 01", ack); end
    mem_ready = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b0; req = '0; we = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #2;
    test_reset();
    test_cpu_read();
    test_simultaneous();
    test_debug_write();
    test_misaligned();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
